// File: rtl/flaf_pkg.sv
// flaf_pkg: shared constants, derived widths and FSM encoding for the FLAF datapath stages.
package flaf_pkg;
    localparam int DEF_Q_ORD    = 3;
    localparam int DEF_WIDTH    = 16;
    localparam int DEF_QP       = 12;
    localparam int DEF_N_TAPS   = 4;
    localparam int DEF_MU_SHIFT = 2;
    localparam int L            = DEF_N_TAPS * DEF_Q_ORD;

    typedef enum logic [1:0] {IDLE, MAC, ERR, UPD} state_t;

    function automatic int acc_width(input int width, input int n);
        return 2 * width + $clog2(n);
    endfunction

    // Rounded e*phi after the QP+MU_SHIFT shift, with one spare bit so it never clips.
    function automatic int delta_width(input int width, input int qp, input int mu);
        return 2 * width - qp - mu + 1;
    endfunction
endpackage

// File: rtl/flaf_weight_mac_if.sv
// flaf_weight_mac_if: sample-in / result-out bundle of the FLAF weight MAC.
interface flaf_weight_mac_if
    import flaf_pkg::*;
#(
    parameter int Q_ORD = DEF_Q_ORD,
    parameter int WIDTH = DEF_WIDTH
);
    logic [Q_ORD*WIDTH-1:0] phi_packed;
    logic [WIDTH-1:0]       d_in;
    logic                   in_valid;
    logic                   in_ready;
    logic                   adapt_en;
    logic [WIDTH-1:0]       y_out;
    logic [WIDTH-1:0]       e_out;
    logic                   out_valid;

    modport master (
        output phi_packed, d_in, in_valid, adapt_en,
        input  in_ready, y_out, e_out, out_valid
    );
    modport slave (
        input  phi_packed, d_in, in_valid, adapt_en,
        output in_ready, y_out, e_out, out_valid
    );
endinterface

// File: rtl/flaf_sat_round.sv
// flaf_sat_round: signed round-half-up arithmetic right shift by SH, then clamp to OW bits.
module flaf_sat_round #(
    parameter int IW = 32,
    parameter int SH = 0,
    parameter int OW = 16
) (
    input  logic signed [IW-1:0] a,
    output logic signed [OW-1:0] y
);
    localparam logic signed [IW:0] RND  = SH > 0 ? (IW+1)'(1) <<< (SH > 0 ? SH - 1 : 0) : '0;
    localparam logic signed [IW:0] MAXV = {{(IW+2-OW){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [IW:0] MINV = {{(IW+2-OW){1'b1}}, {(OW-1){1'b0}}};

    logic signed [IW:0] sh;

    // One guard bit keeps the rounding add from overflowing before the shift.
    assign sh = ((IW+1)'(a) + RND) >>> SH;
    assign y  = sh > MAXV ? MAXV[OW-1:0] : sh < MINV ? MINV[OW-1:0] : sh[OW-1:0];
endmodule

// File: rtl/flaf_weight_mac.sv
// flaf_weight_mac: tapped Phi-feature delay line, time-multiplexed MAC for y = w.phi,
// saturated error e = d - y and a sequential LMS weight update, all on one multiplier.
module flaf_weight_mac
    import flaf_pkg::*;
#(
    parameter int Q_ORD    = DEF_Q_ORD,
    parameter int WIDTH    = DEF_WIDTH,
    parameter int QP       = DEF_QP,
    parameter int N_TAPS   = DEF_N_TAPS,
    parameter int MU_SHIFT = DEF_MU_SHIFT
) (
    input logic clk,
    input logic reset,
    flaf_weight_mac_if.slave bus
);
    localparam int NUM_W   = N_TAPS * Q_ORD;
    localparam int IDX_W   = $clog2(NUM_W);
    localparam int ACC_W   = acc_width(WIDTH, NUM_W);
    localparam int DELTA_W = delta_width(WIDTH, QP, MU_SHIFT);

    state_t                    state, state_nxt;
    logic [IDX_W-1:0]          idx;
    logic signed [WIDTH-1:0]   taps [NUM_W];
    logic signed [WIDTH-1:0]   w [NUM_W];
    logic signed [WIDTH-1:0]   d_q;
    logic                      adapt_q;
    logic signed [ACC_W-1:0]   acc, acc_sum;
    logic signed [WIDTH-1:0]   op_a, op_b, y_sat, e_sat, w_new;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [WIDTH:0]     diff;
    logic signed [DELTA_W-1:0] delta;
    logic signed [DELTA_W:0]   w_sum;
    logic                      accept, last;

    assign accept       = bus.in_valid && state == IDLE;
    assign last         = idx == IDX_W'(NUM_W - 1);
    assign bus.in_ready = state == IDLE;

    // Taps are stored flat: index i holds tap i/Q_ORD, feature i%Q_ORD, so one index drives both phases.
    assign op_a    = state == UPD ? $signed(bus.e_out) : w[idx];
    assign op_b    = taps[idx];
    assign prod    = op_a * op_b;
    assign acc_sum = acc + ACC_W'(prod);
    assign diff    = {d_q[WIDTH-1], d_q} - {y_sat[WIDTH-1], y_sat};
    assign w_sum   = (DELTA_W+1)'(w[idx]) + (DELTA_W+1)'(delta);

    flaf_sat_round #(.IW(ACC_W), .SH(QP), .OW(WIDTH)) u_y (.a(acc_sum), .y(y_sat));
    flaf_sat_round #(.IW(WIDTH+1), .SH(0), .OW(WIDTH)) u_e (.a(diff), .y(e_sat));
    flaf_sat_round #(.IW(2*WIDTH), .SH(QP+MU_SHIFT), .OW(DELTA_W)) u_d (.a(prod), .y(delta));
    flaf_sat_round #(.IW(DELTA_W+1), .SH(0), .OW(WIDTH)) u_w (.a(w_sum), .y(w_new));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = bus.in_valid ? MAC : IDLE;
            MAC:     state_nxt = last ? ERR : MAC;
            ERR:     state_nxt = adapt_q ? UPD : IDLE;
            UPD:     state_nxt = last ? IDLE : UPD;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            idx           <= '0;
            acc           <= '0;
            d_q           <= '0;
            adapt_q       <= 1'b0;
            bus.y_out     <= '0;
            bus.e_out     <= '0;
            bus.out_valid <= 1'b0;
            for (int i = 0; i < NUM_W; i++) begin
                taps[i] <= '0;
                w[i]    <= '0;
            end
        end else begin
            state         <= state_nxt;
            bus.out_valid <= state == ERR;
            idx           <= (state == MAC || state == UPD) && !last ? idx + 1'b1 : '0;
            if (accept) begin
                acc     <= '0;
                d_q     <= bus.d_in;
                adapt_q <= bus.adapt_en;
                for (int i = 0; i < Q_ORD; i++)
                    taps[i] <= bus.phi_packed[i*WIDTH +: WIDTH];
                for (int i = Q_ORD; i < NUM_W; i++)
                    taps[i] <= taps[i-Q_ORD];
            end
            if (state == MAC)
                acc <= acc_sum;
            // y and e are taken from the final accumulation at the MAC exit edge.
            if (state == MAC && last) begin
                bus.y_out <= y_sat;
                bus.e_out <= e_sat;
            end
            if (state == UPD)
                w[idx] <= w_new;
        end
    end
endmodule
